// File: rtl/nand_op_sequencer.sv
// NAND operation sequencer: walks read/program/erase/status operations through
// command, address, data and status steps on the timing controller, waits on
// R/B# with a timeout and reports pass/fail per operation.
module nand_op_sequencer #(
   parameter int unsigned RB_DLY = 8,
   parameter int unsigned TO_W   = 24
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            op_req,
   input  logic [1:0]      op_type,
   input  logic [15:0]     op_col,
   input  logic [23:0]     op_row,
   input  logic            ecc_en,
   input  logic [15:0]     cfg_settime,
   input  logic [15:0]     cfg_holdtime,
   input  logic [TO_W-1:0] cfg_timeout,
   input  logic            rnb_i,
   input  logic [7:0]      status_i,
   output logic            tc_start,
   output logic [2:0]      tc_cmd_code,
   output logic [15:0]     tc_settime,
   output logic [15:0]     tc_holdtime,
   input  logic            tc_done,
   output logic [7:0]      cmd_byte_o,
   output logic            op_busy,
   output logic            op_done,
   output logic [1:0]      op_err,
   output logic [7:0]      status_o
);

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_PROG  = 2'b01;
   localparam logic [1:0] OP_ERASE = 2'b10;
   localparam logic [1:0] OP_STAT  = 2'b11;
   localparam int unsigned DLY_W   = (RB_DLY > 2) ? $clog2(RB_DLY) : 1;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RB_DLY, S_RB_WAIT, S_DONE} state_e;
   typedef enum logic [2:0] {K_CMD, K_ADDR, K_DATA, K_STAT, K_RB, K_END} kind_e;
   typedef struct packed {
      kind_e      kind;
      logic [7:0] cmd;
   } step_t;

   // Step table: what each step index means for a given operation type.
   function automatic step_t step_lookup(input logic [1:0] op, input logic [2:0] idx);
      step_t s;
      s = '{K_END, 8'h00};
      case (op)
         OP_READ: case (idx)
            3'd0:    s = '{K_CMD,  8'h00};
            3'd1:    s = '{K_ADDR, 8'h00};
            3'd2:    s = '{K_CMD,  8'h30};
            3'd3:    s = '{K_RB,   8'h00};
            3'd4:    s = '{K_DATA, 8'h00};
            default: s = '{K_END,  8'h00};
         endcase
         OP_PROG: case (idx)
            3'd0:    s = '{K_CMD,  8'h80};
            3'd1:    s = '{K_ADDR, 8'h00};
            3'd2:    s = '{K_DATA, 8'h00};
            3'd3:    s = '{K_CMD,  8'h10};
            3'd4:    s = '{K_RB,   8'h00};
            3'd5:    s = '{K_CMD,  8'h70};
            3'd6:    s = '{K_STAT, 8'h00};
            default: s = '{K_END,  8'h00};
         endcase
         OP_ERASE: case (idx)
            3'd0:    s = '{K_CMD,  8'h60};
            3'd1:    s = '{K_ADDR, 8'h00};
            3'd2:    s = '{K_CMD,  8'hD0};
            3'd3:    s = '{K_RB,   8'h00};
            3'd4:    s = '{K_CMD,  8'h70};
            3'd5:    s = '{K_STAT, 8'h00};
            default: s = '{K_END,  8'h00};
         endcase
         OP_STAT: case (idx)
            3'd0:    s = '{K_CMD,  8'h70};
            3'd1:    s = '{K_STAT, 8'h00};
            default: s = '{K_END,  8'h00};
         endcase
      endcase
      return s;
   endfunction

   state_e          state_q, state_d;
   logic [2:0]      step_q, step_d;
   logic [2:0]      addr_q, addr_d;
   logic [DLY_W-1:0] dly_q, dly_d;
   logic [TO_W-1:0] to_q, to_d;
   logic [1:0]      err_q, err_d;
   logic [7:0]      status_q, status_d;
   logic [1:0]      sync_q;
   logic [1:0]      op_q;
   logic [15:0]     col_q;
   logic [23:0]     row_q;
   logic            ecc_q;
   logic [15:0]     set_q, hold_q;
   logic [TO_W-1:0] tmo_q;

   step_t           cur_step, nxt_step;
   logic [2:0]      addr_last;
   logic [7:0]      addr_byte;
   logic [2:0]      step_code;
   logic [7:0]      step_byte;
   logic            accept;
   logic            advance;
   logic            rnb_s;
   logic [TO_W-1:0] to_inc;

   assign accept = (state_q == S_IDLE) && op_req;
   assign rnb_s  = sync_q[1];
   assign to_inc = to_q + TO_W'(1);

   // Decode the current and following step into bus code and byte.
   always_comb begin
      cur_step  = step_lookup(op_q, step_q);
      nxt_step  = step_lookup(op_q, step_q + 3'd1);
      addr_last = (op_q == OP_ERASE) ? 3'd2 : 3'd4;
      addr_byte = '0;
      if (op_q == OP_ERASE) begin
         case (addr_q)
            3'd0:    addr_byte = row_q[7:0];
            3'd1:    addr_byte = row_q[15:8];
            default: addr_byte = row_q[23:16];
         endcase
      end else begin
         case (addr_q)
            3'd0:    addr_byte = col_q[7:0];
            3'd1:    addr_byte = col_q[15:8];
            3'd2:    addr_byte = row_q[7:0];
            3'd3:    addr_byte = row_q[15:8];
            default: addr_byte = row_q[23:16];
         endcase
      end
      step_code = 3'b000;
      step_byte = '0;
      case (cur_step.kind)
         K_CMD:  begin step_code = 3'b000; step_byte = cur_step.cmd; end
         K_ADDR: begin step_code = 3'b001; step_byte = addr_byte;    end
         K_STAT: step_code = 3'b010;
         K_DATA: step_code = (op_q == OP_READ) ? {2'b10, ~ecc_q} : {2'b11, ~ecc_q};
         default: step_code = 3'b000;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next state plus step, address, delay, timeout and result bookkeeping.
   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      addr_d   = addr_q;
      dly_d    = dly_q;
      to_d     = to_q;
      err_d    = err_q;
      status_d = status_q;
      advance  = 1'b0;
      case (state_q)
         S_IDLE: if (accept) begin
            state_d = S_ISSUE;
            step_d  = '0;
            addr_d  = '0;
            err_d   = '0;
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: if (tc_done) begin
            if (cur_step.kind == K_ADDR && addr_q != addr_last) begin
               addr_d  = addr_q + 3'd1;
               state_d = S_ISSUE;
            end else begin
               addr_d  = '0;
               advance = 1'b1;
               if (cur_step.kind == K_STAT) begin
                  status_d = status_i;
                  if (op_q != OP_STAT) err_d[0] = status_i[0];
               end
            end
         end
         S_RB_DLY: begin
            if (dly_q == DLY_W'(RB_DLY - 1)) begin
               state_d = S_RB_WAIT;
               to_d    = '0;
            end else begin
               dly_d = dly_q + DLY_W'(1);
            end
         end
         S_RB_WAIT: begin
            if (rnb_s) begin
               advance = 1'b1;
            end else if (to_inc >= tmo_q) begin
               err_d[1] = 1'b1;
               state_d  = S_DONE;
            end else begin
               to_d = to_inc;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // A finished step moves on to whatever the table lists next.
      if (advance) begin
         step_d = step_q + 3'd1;
         case (nxt_step.kind)
            K_RB: begin
               state_d = S_RB_DLY;
               dly_d   = '0;
            end
            K_END:   state_d = S_DONE;
            default: state_d = S_ISSUE;
         endcase
      end
   end

   // Datapath registers and request capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_q   <= '0;
         addr_q   <= '0;
         dly_q    <= '0;
         to_q     <= '0;
         err_q    <= '0;
         status_q <= '0;
         op_q     <= '0;
         col_q    <= '0;
         row_q    <= '0;
         ecc_q    <= 1'b0;
         set_q    <= '0;
         hold_q   <= '0;
         tmo_q    <= '0;
      end else begin
         step_q   <= step_d;
         addr_q   <= addr_d;
         dly_q    <= dly_d;
         to_q     <= to_d;
         err_q    <= err_d;
         status_q <= status_d;
         if (accept) begin
            op_q   <= op_type;
            col_q  <= op_col;
            row_q  <= op_row;
            ecc_q  <= ecc_en;
            set_q  <= cfg_settime;
            hold_q <= cfg_holdtime;
            tmo_q  <= cfg_timeout;
         end
      end
   end

   // Two-flop synchronizer for the asynchronous R/B# pin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[0], rnb_i};
   end

   // Outputs decoded from state; code and byte held through ISSUE and WAIT.
   always_comb begin
      tc_start    = (state_q == S_ISSUE);
      tc_cmd_code = '0;
      cmd_byte_o  = '0;
      if (state_q == S_ISSUE || state_q == S_WAIT) begin
         tc_cmd_code = step_code;
         cmd_byte_o  = step_byte;
      end
      op_busy     = (state_q != S_IDLE) && (state_q != S_DONE);
      op_done     = (state_q == S_DONE);
      op_err      = err_q;
      status_o    = status_q;
      tc_settime  = set_q;
      tc_holdtime = hold_q;
   end

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Testbench for nand_op_sequencer: a timing-controller/NAND responder plus an
// operation-level model of the expected step list, results and R/B# timing.
module tb_nand_op_sequencer;

   localparam int unsigned RB_DLY = 8;
   localparam int unsigned TO_W   = 24;

   logic            clk, rst;
   logic            op_req, ecc_en, rnb_i, tc_done;
   logic [1:0]      op_type;
   logic [15:0]     op_col, cfg_settime, cfg_holdtime;
   logic [23:0]     op_row;
   logic [TO_W-1:0] cfg_timeout;
   logic [7:0]      status_i;
   logic            tc_start, op_busy, op_done;
   logic [2:0]      tc_cmd_code;
   logic [15:0]     tc_settime, tc_holdtime;
   logic [7:0]      cmd_byte_o, status_o;
   logic [1:0]      op_err;

   nand_op_sequencer #(.RB_DLY(RB_DLY), .TO_W(TO_W)) dut (
      .clk(clk), .rst(rst), .op_req(op_req), .op_type(op_type), .op_col(op_col),
      .op_row(op_row), .ecc_en(ecc_en), .cfg_settime(cfg_settime),
      .cfg_holdtime(cfg_holdtime), .cfg_timeout(cfg_timeout), .rnb_i(rnb_i),
      .status_i(status_i), .tc_start(tc_start), .tc_cmd_code(tc_cmd_code),
      .tc_settime(tc_settime), .tc_holdtime(tc_holdtime), .tc_done(tc_done),
      .cmd_byte_o(cmd_byte_o), .op_busy(op_busy), .op_done(op_done),
      .op_err(op_err), .status_o(status_o)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Responder state (written only by the responder process).
   logic [2:0] obs_code[$];
   logic [7:0] obs_byte[$];
   int         start_cyc_q[$];
   int         done_cyc_q[$];
   logic [2:0] cur_code;
   logic [7:0] cur_byte;
   bit         pend;
   int         lat;
   int         rb_left;
   int         stab_err = 0;
   int         done_cnt = 0;

   // Responder configuration and expectations (written only by the stimulus).
   logic [7:0] tc_stat = 8'h00;
   int         busy_len = 0;
   logic [2:0] exp_code[$];
   logic [7:0] exp_byte[$];
   int         conf_idx;
   logic [7:0] exp_status = 8'h00;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial forever begin
      @(negedge clk);
      if (op_done) done_cnt++;
   end

   // Timing controller and NAND array responder.
   initial begin
      tc_done = 1'b0; status_i = 8'h00; rnb_i = 1'b1;
      pend = 1'b0; lat = 0; rb_left = 0; cur_code = '0; cur_byte = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            tc_done = 1'b0; pend = 1'b0; rb_left = 0; rnb_i = 1'b1;
         end else begin
            if (tc_done) status_i = 8'($urandom);
            tc_done = 1'b0;
            if (busy_len >= 0 && rb_left < 0) begin rnb_i = 1'b1; rb_left = 0; end
            if (rb_left > 0) begin
               rb_left--;
               if (rb_left == 0) rnb_i = 1'b1;
            end
            if (pend) begin
               if (tc_cmd_code !== cur_code || (cur_code <= 3'b001 && cmd_byte_o !== cur_byte))
                  stab_err++;
               if (tc_start) stab_err++;
               lat--;
               if (lat == 0) begin
                  pend = 1'b0;
                  tc_done = 1'b1;
                  done_cyc_q.push_back(cyc);
                  if (cur_code == 3'b010) status_i = tc_stat;
                  if (cur_code == 3'b000 &&
                      (cur_byte == 8'h30 || cur_byte == 8'h10 || cur_byte == 8'hD0) &&
                      busy_len != 0) begin
                     rnb_i = 1'b0;
                     rb_left = (busy_len < 0) ? -1 : busy_len;
                  end
               end
            end else if (tc_start) begin
               obs_code.push_back(tc_cmd_code);
               obs_byte.push_back(cmd_byte_o);
               start_cyc_q.push_back(cyc);
               cur_code = tc_cmd_code;
               cur_byte = cmd_byte_o;
               pend = 1'b1;
               lat = $urandom_range(1, 4);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void push(input logic [2:0] c, input logic [7:0] b);
      exp_code.push_back(c);
      exp_byte.push_back(b);
   endfunction

   // Operation-level model: the ordered list of (code, byte) steps.
   function automatic void build_expect(input logic [1:0] typ, input logic [15:0] col,
                                        input logic [23:0] row, input logic ecc, input bit hit);
      logic [39:0] a;
      a = {row, col};
      exp_code.delete();
      exp_byte.delete();
      conf_idx = -1;
      case (typ)
         2'b00: begin
            push(3'b000, 8'h00);
            for (int i = 0; i < 5; i++) push(3'b001, a[8*i +: 8]);
            conf_idx = 6; push(3'b000, 8'h30);
            push(ecc ? 3'b100 : 3'b101, 8'h00);
         end
         2'b01: begin
            push(3'b000, 8'h80);
            for (int i = 0; i < 5; i++) push(3'b001, a[8*i +: 8]);
            push(ecc ? 3'b110 : 3'b111, 8'h00);
            conf_idx = 7; push(3'b000, 8'h10);
            push(3'b000, 8'h70);
            push(3'b010, 8'h00);
         end
         2'b10: begin
            push(3'b000, 8'h60);
            for (int i = 0; i < 3; i++) push(3'b001, row[8*i +: 8]);
            conf_idx = 4; push(3'b000, 8'hD0);
            push(3'b000, 8'h70);
            push(3'b010, 8'h00);
         end
         default: begin
            push(3'b000, 8'h70);
            push(3'b010, 8'h00);
         end
      endcase
      if (hit) begin
         while (exp_code.size() > conf_idx + 1) begin
            void'(exp_code.pop_back());
            void'(exp_byte.pop_back());
         end
      end
   endfunction

   // busy < 0: R/B# stays low after the confirm; 0: never drops; >0: low that many cycles.
   task automatic run_op(input logic [1:0] typ, input logic [15:0] col, input logic [23:0] row,
                         input logic ecc, input logic [7:0] stat, input int busy,
                         input logic [23:0] tmo, input logic [15:0] st, input logic [15:0] ht,
                         input bit poke);
      int ob, db, sb, dc, n, t_done;
      bit hit;
      logic [1:0] exp_err;
      hit = (busy < 0) && (typ != 2'b11);
      build_expect(typ, col, row, ecc, hit);
      if (hit)                                exp_err = 2'b10;
      else if (typ == 2'b01 || typ == 2'b10)  exp_err = {1'b0, stat[0]};
      else                                    exp_err = 2'b00;
      if (!hit && typ != 2'b00) exp_status = stat;
      tc_stat = stat;
      busy_len = busy;
      ob = obs_code.size(); db = done_cyc_q.size(); sb = stab_err; dc = done_cnt;
      @(negedge clk);
      op_req = 1'b1; op_type = typ; op_col = col; op_row = row; ecc_en = ecc;
      cfg_settime = st; cfg_holdtime = ht; cfg_timeout = tmo;
      @(negedge clk);
      op_req = 1'b0;
      op_type = 2'($urandom); op_col = 16'($urandom); op_row = 24'($urandom);
      ecc_en = 1'($urandom); cfg_settime = 16'($urandom); cfg_holdtime = 16'($urandom);
      cfg_timeout = 24'($urandom_range(1, 5));
      check("busy_after_accept", 64'(op_busy), 64'(1));
      check("err_cleared_on_accept", 64'(op_err), 64'(0));
      check("tc_times", 64'({tc_settime, tc_holdtime}), 64'({st, ht}));
      if (poke) begin
         repeat (3) @(negedge clk);
         op_req = 1'b1; op_type = ~typ;
         @(negedge clk);
         op_req = 1'b0;
      end
      n = 0;
      while (!op_done && n < 3000) begin @(negedge clk); n++; end
      t_done = cyc;
      check("op_done_seen", 64'(op_done), 64'(1));
      check("busy_low_at_done", 64'(op_busy), 64'(0));
      check("op_err", 64'(op_err), 64'(exp_err));
      check("status_o", 64'(status_o), 64'(exp_status));
      repeat (6) @(negedge clk);
      check("done_pulses", 64'(done_cnt - dc), 64'(1));
      check("start_count", 64'(obs_code.size() - ob), 64'(exp_code.size()));
      for (int i = 0; i < exp_code.size() && ob + i < obs_code.size(); i++) begin
         check("step_code", 64'({i[7:0], obs_code[ob+i]}), 64'({i[7:0], exp_code[i]}));
         if (exp_code[i] <= 3'b001)
            check("step_byte", 64'({i[7:0], obs_byte[ob+i]}), 64'({i[7:0], exp_byte[i]}));
      end
      check("held_until_done", 64'(stab_err - sb), 64'(0));
      // Timeout: RB_DLY delay cycles, then cfg_timeout wait cycles, then the DONE cycle.
      if (hit && done_cyc_q.size() > db + conf_idx)
         check("timeout_latency", 64'(t_done - done_cyc_q[db+conf_idx]), 64'(RB_DLY + tmo + 1));
      // R/B# already high: RB_DLY cycles, one RB_WAIT cycle, then ISSUE.
      if (busy == 0 && conf_idx >= 0 && done_cyc_q.size() > db + conf_idx &&
          start_cyc_q.size() > ob + conf_idx + 1)
         check("rb_fast_resume", 64'(start_cyc_q[ob+conf_idx+1] - done_cyc_q[db+conf_idx]),
               64'(RB_DLY + 2));
   endtask

   initial begin
      int ob, dc, n, busy;
      logic [1:0] typ;
      logic [23:0] tmo;
      rst = 1'b1; op_req = 1'b0; op_type = '0; op_col = '0; op_row = '0; ecc_en = 1'b0;
      cfg_settime = '0; cfg_holdtime = '0; cfg_timeout = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", 64'({tc_start, tc_cmd_code, tc_settime, tc_holdtime, cmd_byte_o,
                                  op_busy, op_done, op_err, status_o}), 64'(0));
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_op(2'b11, 16'h0000, 24'h000000, 1'b0, 8'hE0, 0, 24'd100, 16'd2, 16'd2, 1'b0);
      run_op(2'b00, 16'h0123, 24'h045678, 1'b0, 8'h00, 12, 24'd100,
             16'($urandom), 16'($urandom), 1'b1);
      run_op(2'b01, 16'($urandom), 24'($urandom), 1'b1, 8'hC1, 15, 24'd100,
             16'($urandom), 16'($urandom), 1'b0);
      run_op(2'b10, 16'($urandom), 24'($urandom), 1'b0, 8'h3C, 0, 24'd100,
             16'($urandom), 16'($urandom), 1'b0);
      run_op(2'b10, 16'($urandom), 24'($urandom), 1'b0, 8'h55, -1, 24'd100,
             16'($urandom), 16'($urandom), 1'b0);
      run_op(2'b00, 16'($urandom), 24'($urandom), 1'b1, 8'h00, -1, 24'd40,
             16'($urandom), 16'($urandom), 1'b0);

      // Request while busy is ignored; reset mid-address aborts with no op_done.
      busy_len = 20;
      ob = obs_code.size(); dc = done_cnt;
      @(negedge clk);
      op_req = 1'b1; op_type = 2'b00; op_col = 16'hBEEF; op_row = 24'h123456;
      @(negedge clk);
      op_req = 1'b0;
      @(negedge clk);
      op_req = 1'b1; op_type = 2'b11;
      @(negedge clk);
      op_req = 1'b0;
      n = 0;
      while ((obs_code.size() - ob) < 3 && n < 200) begin @(negedge clk); n++; end
      check("mid_op_reached_addr", 64'((obs_code.size() - ob) >= 3), 64'(1));
      if (obs_code.size() - ob >= 3) begin
         check("first_cmd_not_replaced", 64'({obs_code[ob], obs_byte[ob]}), 64'({3'b000, 8'h00}));
         check("addr_step_code", 64'(obs_code[ob+1]), 64'(3'b001));
      end
      rst = 1'b1;
      exp_status = 8'h00;
      @(negedge clk);
      check("reset_mid_op_outputs", 64'({tc_start, tc_cmd_code, tc_settime, tc_holdtime,
                                         cmd_byte_o, op_busy, op_done, op_err, status_o}), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      ob = obs_code.size();
      repeat (30) @(negedge clk);
      check("no_done_after_abort", 64'(done_cnt - dc), 64'(0));
      check("idle_after_abort", 64'(obs_code.size() - ob), 64'(0));

      run_op(2'b11, 16'($urandom), 24'($urandom), 1'b0, 8'($urandom), 0, 24'd100,
             16'($urandom), 16'($urandom), 1'b0);

      for (int k = 0; k < 10; k++) begin
         typ  = 2'($urandom);
         busy = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 30));
         tmo  = (busy < 0) ? 24'($urandom_range(10, 50)) : 24'($urandom_range(60, 120));
         run_op(typ, 16'($urandom), 24'($urandom), 1'($urandom), 8'($urandom), busy, tmo,
                16'($urandom), 16'($urandom), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
